// File: rtl/vram_scan_reader_if.sv
// Video read port between the scan reader and the data memory.
// The memory returns Rdv one cycle after av is presented.
interface vram_scan_reader_if;
    logic [31:0] av;
    logic [31:0] Rdv;

    modport master (output av, input Rdv);
    modport slave (input av, output Rdv);
endinterface

// File: rtl/vram_scan_reader.sv
// Scans VRAM words over the video port and serialises them into 8-bit pixels with sync.
// Define VRAM_BYTE_ADDR_EN to drive av as a byte address (word index << 2).
module vram_scan_reader #(
    parameter int unsigned H_ACTIVE  = 16,
    parameter int unsigned H_FP      = 1,
    parameter int unsigned H_SYNC    = 2,
    parameter int unsigned H_BP      = 1,
    parameter int unsigned V_ACTIVE  = 16,
    parameter int unsigned V_FP      = 1,
    parameter int unsigned V_SYNC    = 1,
    parameter int unsigned V_BP      = 1,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    vram_scan_reader_if.master        vbus,
    output logic [7:0]                pixel,
    output logic                      de,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      frame_start
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] HA      = 16'(H_ACTIVE);
    localparam logic [15:0] HS_LO   = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_HI   = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] HT_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] HT_PRE  = 16'(H_TOTAL - 2);
    localparam logic [15:0] VA      = 16'(V_ACTIVE);
    localparam logic [15:0] VS_LO   = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_HI   = 16'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [15:0] VT_LAST = 16'(V_TOTAL - 1);
    localparam logic [31:0] BASE    = 32'(BASE_ADDR);

    typedef enum logic [1:0] {StIdle, StPrime, StScan} state_e;

    state_e      state_q;
    logic        prime_q;
    logic [15:0] h_q, v_q;
    logic [31:0] word_q;
    logic [31:0] shift_q;

    logic [15:0] h_nxt, v_nxt, tgt_h, tgt_v;
    logic        act, load, fetch_mid, fetch_line, wrap;
    logic [31:0] word_nxt;

    function automatic logic [31:0] word_addr(input logic [31:0] w);
`ifdef VRAM_BYTE_ADDR_EN
        return (BASE + w) << 2;
`else
        return BASE + w;
`endif
    endfunction

    // Everything below is decoded for the position the counters move to on this edge.
    always_comb begin
        h_nxt = (h_q == HT_LAST) ? 16'd0 : h_q + 16'd1;
        v_nxt = v_q;
        if (h_q == HT_LAST) begin
            v_nxt = (v_q == VT_LAST) ? 16'd0 : v_q + 16'd1;
        end
        tgt_h      = (state_q == StScan) ? h_nxt : 16'd0;
        tgt_v      = (state_q == StScan) ? v_nxt : 16'd0;
        act        = (tgt_h < HA) && (tgt_v < VA);
        load       = act && (tgt_h[1:0] == 2'd0);
        fetch_mid  = (tgt_v < VA) && (tgt_h[1:0] == 2'd2) && (tgt_h + 16'd6 <= HA);
        fetch_line = (tgt_h == HT_PRE) && ((tgt_v + 16'd1 < VA) || (tgt_v == VT_LAST));
        wrap       = fetch_line && (tgt_v == VT_LAST);
        word_nxt   = wrap ? 32'd0 : word_q + 32'd1;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StIdle;
            prime_q     <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            vbus.av     <= word_addr(32'd0);
            pixel       <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (state_q == StIdle || !enable) begin
            state_q     <= (state_q == StIdle && enable) ? StPrime : StIdle;
            prime_q     <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            word_q      <= '0;
            shift_q     <= '0;
            vbus.av     <= word_addr(32'd0);
            pixel       <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else if (state_q == StPrime && !prime_q) begin
            prime_q <= 1'b1;
        end else begin
            // Second PRIME cycle and every SCAN cycle share this path; PRIME targets (0,0).
            state_q     <= StScan;
            h_q         <= tgt_h;
            v_q         <= tgt_v;
            de          <= act;
            hsync       <= !((tgt_h >= HS_LO) && (tgt_h < HS_HI));
            vsync       <= !((tgt_v >= VS_LO) && (tgt_v < VS_HI));
            frame_start <= (tgt_h == 16'd0) && (tgt_v == 16'd0);
            if (load) begin
                shift_q <= vbus.Rdv;
                pixel   <= vbus.Rdv[7:0];
            end else if (act) begin
                shift_q <= {8'h00, shift_q[31:8]};
                pixel   <= shift_q[15:8];
            end else begin
                pixel <= '0;
            end
            if (fetch_mid || fetch_line) begin
                word_q  <= word_nxt;
                vbus.av <= word_addr(word_nxt);
            end
        end
    end

endmodule

// File: tb/tb_vram_scan_reader.sv
// Directed bench for vram_scan_reader with default geometry (20 x 19 totals).
module tb_vram_scan_reader;

`ifdef VRAM_BYTE_ADDR_EN
    localparam int ASH = 2;
`else
    localparam int ASH = 0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] pixel;
    logic       de, hsync, vsync, frame_start;

    logic [31:0] mem [64];
    int          n_pass = 0;
    int          n_checks = 0;
    int          fetches;
    int          h, v;
    logic        exp_de;
    logic [31:0] prev_av;

    vram_scan_reader_if vbus ();

    vram_scan_reader dut (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (enable),
        .vbus        (vbus),
        .pixel       (pixel),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 CLK = ~CLK;

    // Synchronous-read video port model: data one cycle after the address.
    always @(posedge CLK) vbus.Rdv <= mem[6'(vbus.av >> ASH)];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int n = 0; n < 64; n++) mem[n] = {4{8'(n)}};
        mem[0] = 32'h4433_2211;

        // Reset state
        step(1);
        check("rst_de", 32'(de), 32'd0);
        check("rst_hsync", 32'(hsync), 32'd1);
        check("rst_vsync", 32'(vsync), 32'd1);
        check("rst_pixel", 32'(pixel), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        check("rst_av", vbus.av, 32'd0);
        RST = 1'b1;
        step(2);
        check("idle_de", 32'(de), 32'd0);

        // Start-up latency and byte order
        enable = 1'b1;
        step(1);
        check("prime1_fs", 32'(frame_start), 32'd0);
        step(1);
        check("prime2_fs", 32'(frame_start), 32'd0);
        check("prime2_de", 32'(de), 32'd0);
        step(1);
        check("start_fs", 32'(frame_start), 32'd1);
        check("start_de", 32'(de), 32'd1);
        check("pix0", 32'(pixel), 32'h11);
        step(1);
        check("pix1", 32'(pixel), 32'h22);
        check("pix1_fs", 32'(frame_start), 32'd0);
        step(1);
        check("pix2", 32'(pixel), 32'h33);
        step(1);
        check("pix3", 32'(pixel), 32'h44);

        // Restart with word n = n in every byte
        enable = 1'b0;
        step(1);
        check("stop_de", 32'(de), 32'd0);
        mem[0] = 32'h0;
        enable = 1'b1;
        step(3);
        check("restart_fs", 32'(frame_start), 32'd1);

        // One full frame from (0,0)
        fetches = 0;
        for (int c = 0; c < 380; c++) begin
            h = c % 20;
            v = c / 20;
            exp_de = (h < 16) && (v < 16);
            check("de", 32'(de), 32'(exp_de));
            check("hsync", 32'(hsync), 32'(!(h == 17 || h == 18)));
            check("vsync", 32'(vsync), 32'(v != 17));
            check("fs", 32'(frame_start), 32'(c == 0));
            if (exp_de) check("pixel", 32'(pixel), 32'(v * 4 + h / 4));
            if (h == 18 && v == 0) check("av_line1", vbus.av, 32'(4 << ASH));
            if (h == 2 && v == 1) check("av_word5", vbus.av, 32'(5 << ASH));
            if (h == 17 && v == 18) check("av_hold", vbus.av, 32'(63 << ASH));
            if (h == 18 && v == 18) check("av_wrap", vbus.av, 32'd0);
            prev_av = vbus.av;
            step(1);
            if (vbus.av != prev_av) fetches++;
        end
        check("fetches", 32'(fetches), 32'd64);
        check("frame2_fs", 32'(frame_start), 32'd1);
        check("frame2_de", 32'(de), 32'd1);
        check("frame2_pix", 32'(pixel), 32'h00);

        // Drop enable at h=5, v=3
        step(65);
        check("h5v3_pix", 32'(pixel), 32'd13);
        enable = 1'b0;
        step(1);
        check("drop_de", 32'(de), 32'd0);
        check("drop_hsync", 32'(hsync), 32'd1);
        check("drop_vsync", 32'(vsync), 32'd1);
        check("drop_av", vbus.av, 32'd0);
        check("drop_pixel", 32'(pixel), 32'd0);
        enable = 1'b1;
        step(2);
        check("reen_fs_early", 32'(frame_start), 32'd0);
        step(1);
        check("reen_fs", 32'(frame_start), 32'd1);

        // Asynchronous reset between edges
        step(6);
        check("pre_rst_pix", 32'(pixel), 32'd1);
        check("pre_rst_av", vbus.av, 32'(2 << ASH));
        #3 RST = 1'b0;
        #1;
        check("arst_de", 32'(de), 32'd0);
        check("arst_pixel", 32'(pixel), 32'd0);
        check("arst_av", vbus.av, 32'd0);
        check("arst_fs", 32'(frame_start), 32'd0);
        @(negedge CLK) RST = 1'b1;
        step(2);
        check("post_rst_fs_early", 32'(frame_start), 32'd0);
        step(1);
        check("post_rst_fs", 32'(frame_start), 32'd1);
        check("post_rst_de", 32'(de), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vram_scan_reader.md
Name: vram_scan_reader

Overview:
- Reads the video port of the data memory and turns its stored 32-bit words into a raster pixel stream with sync signals for the display side.
- Drives the memory's video address (av) sequentially, captures the returned word (Rdv) one cycle later, and serialises it into 8-bit pixels.
- Runs on one clock. The memory's video clock is tied to the same CLK at top level.

Parameters:
- H_ACTIVE, 16, active pixels per line; must be a multiple of 4.
- H_FP, 1, horizontal front porch in pixels.
- H_SYNC, 2, hsync pulse width in pixels.
- H_BP, 1, horizontal back porch in pixels; H_FP+H_SYNC+H_BP >= 2.
- V_ACTIVE, 16, active lines per frame.
- V_FP, 1, vertical front porch in lines.
- V_SYNC, 1, vsync pulse width in lines.
- V_BP, 1, vertical back porch in lines.
- BASE_ADDR, 0, word index of pixel (0,0).

Ports:
- CLK  in  1  system/pixel clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- enable  in  1  scan enable.
- av  out  32  video read address to memory (registered).
- Rdv  in  32  video read data from memory; valid the cycle after av is presented.
- pixel  out  8  current pixel (registered).
- de  out  1  display enable; pixel valid.
- hsync  out  1  horizontal sync, active low.
- vsync  out  1  vertical sync, active low.
- frame_start  out  1  one-cycle pulse coinciding with pixel (0,0).

Behaviour:
- Derived values: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; WPL = H_ACTIVE/4 words per line.
- Reset (RST=0, asynchronous):
  - state=IDLE; h=v=0.
  - av=BASE_ADDR; pixel=0; de=0; hsync=1; vsync=1; frame_start=0.
  - Shift register cleared.
- States: IDLE, PRIME, SCAN.
- IDLE:
  - Outputs held at their reset values; av=BASE_ADDR.
  - Moves to PRIME when enable=1.
- PRIME:
  - Lasts exactly 2 cycles, with av=BASE_ADDR.
  - On the second cycle, Rdv is loaded into the shift register.
  - Then moves to SCAN with h=0, v=0.
- SCAN counters:
  - h increments each cycle and wraps at H_TOTAL-1.
  - v increments when h wraps and wraps at V_TOTAL-1.
- Outputs (all registered, updated on the same edge for counter position (h,v)):
  - de=1 iff h<H_ACTIVE and v<V_ACTIVE.
  - hsync=0 iff H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync=0 iff V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC; it applies for entire lines.
  - frame_start=1 iff h=0 and v=0.
- Pixel order: word k of line y covers h=4k..4k+3. Bits [7:0] are emitted first, then [15:8], [23:16], [31:24]. pixel=0 whenever de=0.
- Fetch timing:
  - The word for h=4k is presented on av while h=4k-2. For k=0 this is h=H_TOTAL-2 of the previous line.
  - Rdv is captured into the shift register at the edge where h becomes 4k.
  - Net latency, av to first pixel of that word: 2 cycles.
- Address sequence:
  - av = BASE_ADDR + y*WPL + k for active lines y.
  - After the last word of line V_ACTIVE-1, the next fetch wraps to BASE_ADDR. It is issued at h=H_TOTAL-2 of line V_TOTAL-1.
  - No fetches during vertical blanking lines other than that one; av holds its last value.
- Words are never fetched twice. Exactly V_ACTIVE*WPL fetches are made per frame.
- enable=0 during PRIME or SCAN:
  - Moves to IDLE on the next edge; outputs return to reset values and counters clear.
  - Re-enabling restarts from PRIME and frame (0,0).
- Reset asserted mid-frame: immediate clear as above. After release, behaves as from IDLE.

Optional Feature:
- Macro: VRAM_BYTE_ADDR_EN.
- Defined: av carries a byte address, (word index)<<2. BASE_ADDR is still a word index. This is for memory ports that divide the address by 4.
- Undefined: av carries the word index directly, as the current video port expects.
- Timing is identical either way.

Test Plan:
- Reset then enable=1, memory word0=0x44332211 -> frame_start and de at the same cycle, 3 cycles after enable sampled; pixel sequence 0x11,0x22,0x33,0x44.
- Full frame, memory word n = n replicated in each byte -> line y pixels 4k..4k+3 equal y*4+k; 64 fetches; av at h=18,v=0 equals 4 (prefetch for line 1).
- Sync check, defaults (H_TOTAL=20, V_TOTAL=19) -> hsync low at h=17..18; vsync low for line 17 only; frame_start every 380 cycles.
- Frame wrap -> av=0 issued at h=18 of v=18; second frame pixel (0,0) equals word0.
- enable dropped at h=5,v=3 -> next cycle de=0, hsync=vsync=1, av=BASE_ADDR; re-enable gives frame_start after 3 cycles.
- RST pulsed low mid-line, asynchronous, between edges -> outputs clear immediately; with VRAM_BYTE_ADDR_EN, av for word 5 reads 20.
